scan_pingpong_ctrl: RTL and testbench
=====================================

# scan_pingpong_ctrl

Host-side controller for a pair of scanner units. It drives `start_scan`, `transfer`, `flush_signal` and `go_to_standby` into both scanners and consumes their `ready_second_buffer`, `start_second_buffer`, `ready_to_transfer` and `data_count` outputs. Scanning alternates between the two units so one buffer fills while the other is transferred. The block sits between the system sequencer (enable/stop) and the two scanner instances.

## Interface
- `FULL_COUNT`, default 100: scanner buffer-full count.
- `WDOG_LIMIT`, default 1024: stall limit in cycles; used only with the watchdog compiled in.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  start request, sampled in IDLE.
- `stop`  in  1  graceful-stop request, sampled every cycle.
- `ready_second_buffer`  in  2  per-unit status, bit n = unit n.
- `start_second_buffer`  in  2  per-unit status.
- `ready_to_transfer`  in  2  per-unit status.
- `data_count0`, `data_count1`  in  8  per-unit fill counts.
- `start_scan`  out  2  one-cycle pulse per unit.
- `go_to_standby`  out  2  one-cycle pulse per unit.
- `transfer`  out  2  level per unit.
- `flush_signal`  out  2  level per unit.
- `active_unit`  out  1  unit currently filling.
- `xfer_words`  out  16  running total of transferred words.
- `busy`  out  1  high in any state except IDLE.
- `fault`  out  1  watchdog trip, sticky until reset; tied 0 without the watchdog.

## Operation
- A = `active_unit`; O = the other unit. `cnt` = data_count of A.
- All outputs are registered. Reset clears every output to 0 and places the FSM in IDLE with `stop_pending`=0.
- **IDLE:** if `enable`, pulse `start_scan[A]` and go to SCAN.
- **SCAN:** when `ready_second_buffer[A]`, pulse `go_to_standby[O]` and go to PREP.
- **PREP:** when `start_second_buffer[A]` or `cnt==FULL_COUNT`, pulse `start_scan[O]` and go to WAIT_FULL.
- **WAIT_FULL:** when `cnt==FULL_COUNT` and `ready_to_transfer[A]`:
  - latch `cnt` into `last_cnt`;
  - if `stop_pending`, raise `flush_signal[A]` and go to DRAIN;
  - otherwise raise `transfer[A]` and go to XFER.
- **XFER:** hold `transfer[A]` until `cnt==0`. On that cycle:
  - drop `transfer[A]`;
  - `xfer_words += last_cnt`, modulo 2^16 (wraps);
  - toggle A.
  - Then go to DRAIN if `stop_pending`, otherwise go to SCAN (the new A is already scanning).
- **DRAIN:**
  - If `flush_signal[A]` is low, wait for `cnt==FULL_COUNT`, then raise it.
  - Hold `flush_signal[A]` until `cnt==0`, then drop it, clear `stop_pending` and go to IDLE.
  - Flushed words are not added to `xfer_words`.
- **stop:** sets `stop_pending` in any non-IDLE state. In IDLE, `stop` alone is ignored. `enable` and `stop` together in IDLE start a run with `stop_pending`=1.
- `enable` is don't-care outside IDLE.
- `transfer[n]` and `flush_signal[n]` are never high in the same cycle.
- At most one unit has `transfer` or `flush_signal` high at any time.

## Timing
- Output response lands on the clock edge after the input condition is sampled (1-cycle latency).
- `start_scan` and `go_to_standby` pulses are exactly 1 cycle wide.
- `transfer` falls on the edge after `cnt==0` is sampled. `active_unit` toggles on the same edge.
- Asynchronous reset mid-transfer drops `transfer` and `flush_signal` immediately. Scanner state is not repaired.

## Configuration
- `SCAN_PINGPONG_WDOG_EN` defined:
  - A 16-bit stall counter runs in WAIT_FULL, XFER and DRAIN.
  - It clears whenever `cnt` changes or the state changes.
  - On reaching `WDOG_LIMIT`: set `fault`, drop all strobes and levels, clear `stop_pending`, go to IDLE.
  - While `fault`=1, IDLE ignores `enable`.
- Macro undefined: no counter; `fault` is constant 0; stalls wait indefinitely.

## Test plan
- Reset with stimulus active -> all outputs 0, `busy`=0; `enable` pulse -> `start_scan`=2'b01 for exactly 1 cycle, next cycle `busy`=1.
- Scanner model ramps `data_count0` 0→100, with `ready_second_buffer` at 80 and `start_second_buffer` at 90:
  - `go_to_standby`=2'b10 pulse 1 cycle after 80;
  - `start_scan`=2'b10 pulse 1 cycle after 90;
  - `transfer`=2'b01 after 100, held until count0=0;
  - then `xfer_words`=100, `active_unit`=1.
- Three full ping-pong cycles -> `transfer` alternates 01,10,01; `xfer_words`=300.
- `stop` during unit-0 XFER:
  - `xfer_words`=100 after count0=0;
  - `flush_signal`=2'b10 once count1=100, held until count1=0;
  - ends in IDLE with `busy`=0 and `xfer_words` still 100.
- 656 consecutive buffers -> `xfer_words` wraps to 64.
- With `SCAN_PINGPONG_WDOG_EN` and `WDOG_LIMIT`=16, hold count0 at 50 in WAIT_FULL -> `fault`=1 after 16 cycles, `busy`=0; subsequent `enable` ignored until reset.

Source files
------------

// File: rtl/scan_pingpong_ctrl.sv
// Ping-pong host controller for two scanner units: one buffer fills while the other transfers.
// Optional stall watchdog is compiled in with `define SCAN_PINGPONG_WDOG_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for enable; no unit active
// SCAN      | active unit scanning, waiting for its ready_second_buffer
// PREP      | other unit sent to standby, waiting to start it scanning
// WAIT_FULL | waiting for active buffer full and ready_to_transfer
// XFER      | transfer asserted on active unit until its count drains to 0
// DRAIN     | graceful stop: flush the pending buffer, then return to IDLE
module scan_pingpong_ctrl #(
    parameter int FULL_COUNT = 100,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        stop,
    input  logic [1:0]  ready_second_buffer,
    input  logic [1:0]  start_second_buffer,
    input  logic [1:0]  ready_to_transfer,
    input  logic [7:0]  data_count0,
    input  logic [7:0]  data_count1,
    output logic [1:0]  start_scan,
    output logic [1:0]  go_to_standby,
    output logic [1:0]  transfer,
    output logic [1:0]  flush_signal,
    output logic        active_unit,
    output logic [15:0] xfer_words,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE, S_SCAN, S_PREP, S_WAIT_FULL, S_XFER, S_DRAIN
    } state_t;

    localparam logic [7:0] FULL_CNT = 8'(FULL_COUNT);

    state_t      state, state_nxt;
    logic        stop_pending, sp_nxt;
    logic [7:0]  last_cnt, last_nxt;
    logic [1:0]  ss_nxt, gts_nxt, tr_nxt, fl_nxt;
    logic        au_nxt;
    logic [15:0] xw_nxt;
    logic [7:0]  cnt;
    logic        cnt_full;
    logic [1:0]  a_mask, o_mask;
    logic        wdog_trip;

    assign cnt      = active_unit ? data_count1 : data_count0;
    assign cnt_full = (cnt == FULL_CNT);
    assign a_mask   = active_unit ? 2'b10 : 2'b01;
    assign o_mask   = ~a_mask;

`ifdef SCAN_PINGPONG_WDOG_EN
    logic [15:0] wdog_cnt;
    logic [7:0]  cnt_q;
    logic        fault_q;
    logic        stall_state;

    assign stall_state = (state == S_WAIT_FULL) || (state == S_XFER) || (state == S_DRAIN);
    assign wdog_trip   = stall_state && (cnt == cnt_q) && (wdog_cnt == 16'(WDOG_LIMIT - 1));
    assign fault       = fault_q;

    // Any progress (count movement or state change) restarts the stall window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdog_cnt <= '0;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            cnt_q <= cnt;
            if (!stall_state || (state_nxt != state) || (cnt != cnt_q))
                wdog_cnt <= '0;
            else
                wdog_cnt <= wdog_cnt + 16'd1;
            if (wdog_trip)
                fault_q <= 1'b1;
        end
    end
`else
    assign wdog_trip = 1'b0;
    assign fault     = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        sp_nxt    = stop_pending;
        last_nxt  = last_cnt;
        ss_nxt    = '0;
        gts_nxt   = '0;
        tr_nxt    = transfer;
        fl_nxt    = flush_signal;
        au_nxt    = active_unit;
        xw_nxt    = xfer_words;

        if (state != S_IDLE && stop)
            sp_nxt = 1'b1;

        case (state)
            S_IDLE: begin
                if (enable && !fault) begin
                    ss_nxt    = a_mask;
                    sp_nxt    = stop;
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (ready_second_buffer[active_unit]) begin
                    gts_nxt   = o_mask;
                    state_nxt = S_PREP;
                end
            end
            S_PREP: begin
                if (start_second_buffer[active_unit] || cnt_full) begin
                    ss_nxt    = o_mask;
                    state_nxt = S_WAIT_FULL;
                end
            end
            S_WAIT_FULL: begin
                if (cnt_full && ready_to_transfer[active_unit]) begin
                    last_nxt = cnt;
                    if (stop_pending) begin
                        fl_nxt    = a_mask;
                        state_nxt = S_DRAIN;
                    end else begin
                        tr_nxt    = a_mask;
                        state_nxt = S_XFER;
                    end
                end
            end
            S_XFER: begin
                if (cnt == 8'd0) begin
                    tr_nxt    = '0;
                    xw_nxt    = xfer_words + {8'd0, last_cnt};
                    au_nxt    = ~active_unit;
                    state_nxt = stop_pending ? S_DRAIN : S_SCAN;
                end
            end
            S_DRAIN: begin
                // Entered from XFER the new unit is still filling; flush only once it is full.
                if (flush_signal == 2'b00) begin
                    if (cnt_full)
                        fl_nxt = a_mask;
                end else if (cnt == 8'd0) begin
                    fl_nxt    = '0;
                    sp_nxt    = 1'b0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (wdog_trip) begin
            state_nxt = S_IDLE;
            sp_nxt    = 1'b0;
            ss_nxt    = '0;
            gts_nxt   = '0;
            tr_nxt    = '0;
            fl_nxt    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            stop_pending  <= 1'b0;
            last_cnt      <= '0;
            start_scan    <= '0;
            go_to_standby <= '0;
            transfer      <= '0;
            flush_signal  <= '0;
            active_unit   <= 1'b0;
            xfer_words    <= '0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nxt;
            stop_pending  <= sp_nxt;
            last_cnt      <= last_nxt;
            start_scan    <= ss_nxt;
            go_to_standby <= gts_nxt;
            transfer      <= tr_nxt;
            flush_signal  <= fl_nxt;
            active_unit   <= au_nxt;
            xfer_words    <= xw_nxt;
            busy          <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_scan_pingpong_ctrl.sv
// Self-checking bench for scan_pingpong_ctrl: randomized scanner models plus a sequential reference model.
// Watchdog checks run only when SCAN_PINGPONG_WDOG_EN is defined.
module tb_scan_pingpong_ctrl;
    localparam int FULL = 100;
`ifdef SCAN_PINGPONG_WDOG_EN
    localparam int WLIM = 16;
`else
    localparam int WLIM = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        stop = 1'b0;
    logic [1:0]  rsb = '0, ssb = '0, rtt = '0;
    logic [7:0]  dc0 = '0, dc1 = '0;
    logic [1:0]  start_scan, go_to_standby, transfer, flush_signal;
    logic        active_unit, busy, fault;
    logic [15:0] xfer_words;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0, model_go = 0, scan_on = 0, jitter = 1, saw_f10 = 0;

    scan_pingpong_ctrl #(.FULL_COUNT(FULL), .WDOG_LIMIT(WLIM)) dut (
        .clk(clk), .rst(rst), .enable(enable), .stop(stop),
        .ready_second_buffer(rsb), .start_second_buffer(ssb), .ready_to_transfer(rtt),
        .data_count0(dc0), .data_count1(dc1),
        .start_scan(start_scan), .go_to_standby(go_to_standby), .transfer(transfer),
        .flush_signal(flush_signal), .active_unit(active_unit), .xfer_words(xfer_words),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scanner models (stimulus) ----------------
    int c_u[2] = '{0, 0};
    int ph[2]  = '{0, 0};   // 0 idle, 1 filling, 2 full, 3 draining
    int rd[2]  = '{0, 0};
    initial begin
        forever begin
            @(posedge clk); #2;
            if (scan_on) begin
                for (int n = 0; n < 2; n++) begin
                    if (start_scan[n]) begin
                        ph[n] = 1; c_u[n] = 0; rtt[n] = 1'b0;
                    end else if (ph[n] == 1) begin
                        if (!jitter || $urandom_range(15) != 0) c_u[n]++;
                        if (c_u[n] == FULL) begin
                            ph[n] = 2;
                            rd[n] = jitter ? int'($urandom_range(3)) : 0;
                        end
                    end else if (ph[n] == 2) begin
                        if (transfer[n] || flush_signal[n]) begin
                            ph[n] = 3; c_u[n]--;
                        end else if (rd[n] > 0) rd[n]--;
                        else rtt[n] = 1'b1;
                    end else if (ph[n] == 3) begin
                        if ((transfer[n] || flush_signal[n]) && (!jitter || $urandom_range(15) != 0))
                            c_u[n]--;
                        if (c_u[n] == 0) begin
                            ph[n] = 0; rtt[n] = 1'b0;
                        end
                    end
                    rsb[n] = (ph[n] == 1 || ph[n] == 2) && c_u[n] >= 80;
                    ssb[n] = (ph[n] == 1 || ph[n] == 2) && c_u[n] >= 90;
                end
                dc0 = 8'(c_u[0]);
                dc1 = 8'(c_u[1]);
            end
        end
    end

    // ---------------- reference model ----------------
    logic [1:0]  e_ss = '0, e_gts = '0, e_tr = '0, e_fl = '0;
    logic        e_au = 1'b0, e_busy = 1'b0;
    logic [15:0] e_xw = '0;
    bit          m_sp = 0, m_run = 0, sp_cur = 0;
    logic        s_en, s_stop;
    logic [1:0]  s_rsb, s_ssb, s_rtt;
    logic [7:0]  s_c0, s_c1;

    function automatic logic [7:0] mcnt();
        return e_au ? s_c1 : s_c0;
    endfunction

    function automatic logic [1:0] amask();
        return e_au ? 2'b10 : 2'b01;
    endfunction

    // One clock edge: sample inputs, retire pulses, register a stop request.
    task automatic tick();
        @(posedge clk);
        s_en = enable; s_stop = stop; s_rsb = rsb; s_ssb = ssb; s_rtt = rtt;
        s_c0 = dc0; s_c1 = dc1;
        e_ss = '0; e_gts = '0;
        sp_cur = m_sp;
        if (m_run && s_stop) m_sp = 1;
    endtask

    task automatic drain(bit flushing);
        if (!flushing) begin
            do tick(); while (mcnt() != 8'(FULL));
            e_fl = amask();
        end
        do tick(); while (mcnt() != 8'd0);
        e_fl = '0; m_sp = 0; m_run = 0; e_busy = 1'b0;
    endtask

    initial begin : model
        bit going;
        logic [7:0] last;
        wait (model_go);
        forever begin
            do tick(); while (!s_en);
            m_sp = s_stop; m_run = 1; e_busy = 1'b1; e_ss = amask();
            going = 1;
            while (going) begin
                do tick(); while (!s_rsb[e_au]);
                e_gts = ~amask();
                do tick(); while (!(s_ssb[e_au] || mcnt() == 8'(FULL)));
                e_ss = ~amask();
                do tick(); while (!(mcnt() == 8'(FULL) && s_rtt[e_au]));
                last = mcnt();
                if (sp_cur) begin
                    e_fl = amask();
                    drain(1);
                    going = 0;
                end else begin
                    e_tr = amask();
                    do tick(); while (mcnt() != 8'd0);
                    e_tr = '0; e_xw = e_xw + 16'(last); e_au = ~e_au;
                    if (sp_cur) begin
                        drain(0);
                        going = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en && rst) begin
            check("start_scan", 32'(start_scan), 32'(e_ss));
            check("go_to_standby", 32'(go_to_standby), 32'(e_gts));
            check("transfer", 32'(transfer), 32'(e_tr));
            check("flush_signal", 32'(flush_signal), 32'(e_fl));
            check("active_unit", 32'(active_unit), 32'(e_au));
            check("xfer_words", 32'(xfer_words), 32'(e_xw));
            check("busy", 32'(busy), 32'(e_busy));
            check("fault", 32'(fault), 32'd0);
            check("excl_levels", 32'((transfer & flush_signal) == 2'b00 && !(&(transfer | flush_signal))), 32'd1);
        end
        if (flush_signal == 2'b10) saw_f10 = 1;
    end

    task automatic pulse_enable(bit with_stop);
        @(posedge clk); #3; enable = 1'b1; stop = with_stop;
        @(posedge clk); #3; enable = 1'b0; stop = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #3; stop = 1'b1;
        @(posedge clk); #3; stop = 1'b0;
    endtask

    task automatic wait_xw(logic [15:0] target, int budget, string name);
        int n = 0;
        while (xfer_words !== target && n < budget) begin
            @(negedge clk); n++;
        end
        check(name, 32'(xfer_words), 32'(target));
    endtask

    task automatic wait_idle(int budget, string name);
        int n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk); n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;
        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            enable = 1'b1; stop = 1'($urandom);
            rsb = 2'($urandom); ssb = 2'($urandom); rtt = 2'($urandom);
            dc0 = 8'($urandom); dc1 = 8'($urandom);
            @(negedge clk);
            check("reset_outputs", 32'({start_scan, go_to_standby, transfer, flush_signal,
                                        active_unit, xfer_words, busy, fault}), 32'd0);
        end
        @(posedge clk); #3;
        enable = 1'b0; stop = 1'b0; rsb = '0; ssb = '0; rtt = '0; dc0 = '0; dc1 = '0;
        rst = 1'b1; model_go = 1; scan_on = 1; chk_en = 1; jitter = 1;

        pulse_enable(0);
        @(negedge clk);
        check("first_start_scan", 32'(start_scan), 32'h1);
        @(negedge clk);
        check("start_scan_width", 32'(start_scan), 32'h0);
        check("busy_after_start", 32'(busy), 32'h1);

        wait_xw(16'd100, 3000, "xw_first_buffer");
        check("au_after_first", 32'(active_unit), 32'h1);
        check("model_xw_100", 32'(e_xw), 32'd100);

        wait_xw(16'd300, 6000, "xw_three_buffers");
        check("au_after_three", 32'(active_unit), 32'h1);
        check("model_xw_300", 32'(e_xw), 32'd300);

        // stop while unit 0 is transferring
        n = 0;
        while (transfer !== 2'b01 && n < 4000) begin
            @(negedge clk); n++;
        end
        check("reach_unit0_xfer", 32'(transfer), 32'h1);
        saw_f10 = 0;
        pulse_stop();
        wait_idle(4000, "stop_ends_idle");
        check("xw_after_stop", 32'(xfer_words), 32'd500);
        check("model_xw_500", 32'(e_xw), 32'd500);
        check("flush_unit1_seen", 32'(saw_f10), 32'd1);
        check("au_after_stop", 32'(active_unit), 32'h1);

        // 651 more buffers: 656 total since reset, 65600 wraps to 64
        jitter = 0;
        pulse_enable(0);
        wait_xw(16'd64, 85000, "xw_wrap");
        check("model_xw_wrap", 32'(e_xw), 32'd64);
        pulse_stop();
        wait_idle(4000, "wrap_run_idle");

        jitter = 1;
        for (int r = 0; r < 3; r++) begin
            pulse_enable(1'($urandom));
            repeat ($urandom_range(20, 400)) @(posedge clk);
            pulse_stop();
            wait_idle(4000, "rand_run_idle");
        end

        // asynchronous reset in the middle of a transfer
        pulse_enable(0);
        n = 0;
        while (transfer === 2'b00 && n < 4000) begin
            @(negedge clk); n++;
        end
        check("reach_xfer_for_reset", 32'(transfer != 2'b00), 32'd1);
        @(posedge clk); #3;
        chk_en = 0;
        rst = 1'b0;
        #1;
        check("async_reset_drop", 32'({transfer, flush_signal, busy, active_unit, xfer_words}), 32'd0);

`ifdef SCAN_PINGPONG_WDOG_EN
        scan_on = 0;
        rsb = '0; ssb = '0; rtt = '0; dc0 = '0; dc1 = '0;
        @(posedge clk); #3; rst = 1'b1;
        pulse_enable(0);
        rsb = 2'b01;
        @(posedge clk); #3;
        ssb = 2'b01; dc0 = 8'd50;
        @(posedge clk);
        n = 0;
        while (fault !== 1'b1 && n < 40) begin
            @(posedge clk); n++; #1;
            if (n == 10) check("wdog_not_early", 32'(fault), 32'd0);
        end
        check("wdog_fault", 32'(fault), 32'd1);
        check("wdog_latency", 32'(n >= 14 && n <= 18), 32'd1);
        @(negedge clk);
        check("wdog_idle", 32'({busy, start_scan, transfer, flush_signal}), 32'd0);
        pulse_enable(0);
        @(negedge clk);
        check("wdog_enable_ignored", 32'({busy, start_scan}), 32'd0);
        check("wdog_fault_sticky", 32'(fault), 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
